// File: rtl/mouse_packet_decoder_pkg.sv
// Shared definitions for the PS/2 mouse packet decoder: FSM states, status-byte layout, defaults.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mouse_packet_decoder_pkg;

  // Packet assembly states; the encoding is fixed so that it matches the state seen on debug taps.
  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    UPDATE  = 2'd3
  } state_e;

  // Bit positions inside the status byte (byte 0 of every packet).
  localparam int ST_BTN_LSB = 0;
  localparam int ST_BTN_MSB = 2;
  localparam int ST_SYNC    = 3;
  localparam int ST_XS      = 4;
  localparam int ST_YS      = 5;
  localparam int ST_XOV     = 6;
  localparam int ST_YOV     = 7;

  // 2 ms at 50 MHz.
  localparam int DEFAULT_TIMEOUT_CYC = 100000;

  // Status fields that are still needed once the packet has been framed.
  // The sync bit is only used to qualify byte 0 and is not kept.
  typedef struct packed {
    logic       yov;
    logic       xov;
    logic       ys;
    logic       xs;
    logic [2:0] btn;
  } status_t;

  function automatic status_t status_from_byte(input logic [7:0] b);
    status_t s;
    s.yov = b[ST_YOV];
    s.xov = b[ST_XOV];
    s.ys  = b[ST_YS];
    s.xs  = b[ST_XS];
    s.btn = b[ST_BTN_MSB:ST_BTN_LSB];
    return s;
  endfunction

  // 9-bit two's complement movement. When the mouse flags an overflow the
  // low byte is meaningless, so the delta is pinned to the extreme of its sign.
  function automatic logic [8:0] delta9(input logic sign, input logic ovf, input logic [7:0] lo);
    if (ovf) begin
      return sign ? 9'h100 : 9'h0FF;
    end
    return {sign, lo};
  endfunction

endpackage

// File: rtl/mouse_axis_update.sv
// Computes one axis' next position: sign-extend/saturate the delta, add, clamp to [0, MAX].
// Latency: purely combinational.
// Backpressure: none.
// Ports:
//   pos_cur    current position (unsigned)
//   delta_lo   low 8 bits of the movement byte
//   delta_sign sign bit from the status byte
//   delta_ovf  overflow flag from the status byte
//   pos_next   clamped new position
module mouse_axis_update
  import mouse_packet_decoder_pkg::*;
#(
  parameter int POS_W = 8,
  parameter int MAX   = 159
) (
  input  logic [POS_W-1:0] pos_cur,
  input  logic [7:0]       delta_lo,
  input  logic             delta_sign,
  input  logic             delta_ovf,
  output logic [POS_W-1:0] pos_next
);

  // Two guard bits cover both the negative range and the overshoot past 2^POS_W-1.
  localparam int SUM_W = POS_W + 2;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX);

  logic signed [8:0]       delta_s;
  logic signed [SUM_W-1:0] sum;

  always_comb begin
    delta_s = signed'(delta9(delta_sign, delta_ovf, delta_lo));
    sum     = signed'({2'b00, pos_cur}) + SUM_W'(delta_s);
    if (sum < 0) begin
      pos_next = '0;
    end else if (sum > MAX_S) begin
      pos_next = POS_W'(MAX);
    end else begin
      pos_next = sum[POS_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets into clamped absolute X/Y and button state, counting dropped packets.
// Latency: outputs and PACKET_VALID update two cycles after the cycle carrying the third byte's BYTE_READY.
// Backpressure: none; READ_ENABLE (ENABLE registered) gates the receiver, bytes arriving during UPDATE are dropped.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   ENABLE                mouse initialised and streaming
//   BYTE_READ/ERROR_CODE  received byte and its {stop, parity} error flags, valid with BYTE_READY
//   READ_ENABLE           receiver enable
//   MOUSE_X/Y, BUTTONS    position and {middle,right,left} from the last accepted packet
//   PACKET_VALID          one-cycle pulse per accepted packet
//   PACKET_ERRORS         saturating count of dropped packets
module mouse_packet_decoder
  import mouse_packet_decoder_pkg::*;
#(
  parameter int POS_W       = 8,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [7:0]       BYTE_READ,
  input  logic [1:0]       BYTE_ERROR_CODE,
  input  logic             BYTE_READY,
  output logic             READ_ENABLE,
  output logic [POS_W-1:0] MOUSE_X,
  output logic [POS_W-1:0] MOUSE_Y,
  output logic [2:0]       MOUSE_BUTTONS,
  output logic             PACKET_VALID,
  output logic [7:0]       PACKET_ERRORS
);

  localparam int TIMER_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  state_e             state_q,  state_d;
  logic [TIMER_W-1:0] timer_q,  timer_d;
  status_t            status_q, status_d;
  logic [7:0]         dx_q,     dx_d;
  logic [7:0]         dy_q,     dy_d;
  logic [POS_W-1:0]   pos_x_q,  pos_x_d;
  logic [POS_W-1:0]   pos_y_q,  pos_y_d;
  logic [2:0]         buttons_q, buttons_d;
  logic               valid_q,  valid_d;
  logic [7:0]         errors_q, errors_d;
  logic               read_en_q, read_en_d;

  logic               byte_ok;
  logic               drop_pkt;
  logic [POS_W-1:0]   new_x;
  logic [POS_W-1:0]   new_y;

  mouse_axis_update #(.POS_W(POS_W), .MAX(X_MAX)) u_axis_x (
    .pos_cur    (pos_x_q),
    .delta_lo   (dx_q),
    .delta_sign (status_q.xs),
    .delta_ovf  (status_q.xov),
    .pos_next   (new_x)
  );

  mouse_axis_update #(.POS_W(POS_W), .MAX(Y_MAX)) u_axis_y (
    .pos_cur    (pos_y_q),
    .delta_lo   (dy_q),
    .delta_sign (status_q.ys),
    .delta_ovf  (status_q.yov),
    .pos_next   (new_y)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = '0;        // cleared on accepted bytes, in WAIT_B0 and on any exit
    status_d  = status_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    errors_d  = errors_q;
    read_en_d = ENABLE;
    drop_pkt  = 1'b0;
    byte_ok   = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);

    if (!ENABLE) begin
      // Host is reconfiguring the mouse: abandon quietly, nothing committed.
      state_d = WAIT_B0;
    end else begin
      case (state_q)
        WAIT_B0: begin
          if (BYTE_READY) begin
            if (byte_ok && BYTE_READ[ST_SYNC]) begin
              status_d = status_from_byte(BYTE_READ);
              state_d  = WAIT_B1;
            end else begin
              drop_pkt = 1'b1;
            end
          end
        end

        WAIT_B1: begin
          if (BYTE_READY) begin
            if (byte_ok) begin
              dx_d    = BYTE_READ;
              state_d = WAIT_B2;
            end else begin
              drop_pkt = 1'b1;
              state_d  = WAIT_B0;
            end
          end else if (timer_q == TIMER_LAST) begin
            drop_pkt = 1'b1;
            state_d  = WAIT_B0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        WAIT_B2: begin
          if (BYTE_READY) begin
            if (byte_ok) begin
              dy_d    = BYTE_READ;
              state_d = UPDATE;
            end else begin
              drop_pkt = 1'b1;
              state_d  = WAIT_B0;
            end
          end else if (timer_q == TIMER_LAST) begin
            drop_pkt = 1'b1;
            state_d  = WAIT_B0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        UPDATE: begin
          // A byte here is ignored: PS/2 bytes are ~1 ms apart, so none can land in this one cycle.
          pos_x_d   = new_x;
          pos_y_d   = new_y;
          buttons_d = status_q.btn;
          valid_d   = 1'b1;
          state_d   = WAIT_B0;
        end

        default: state_d = WAIT_B0;
      endcase
    end

    if (drop_pkt && (errors_q != 8'hFF)) begin
      errors_d = errors_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= WAIT_B0;
      timer_q   <= '0;
      status_q  <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      pos_x_q   <= POS_W'(X_MAX / 2);
      pos_y_q   <= POS_W'(Y_MAX / 2);
      buttons_q <= '0;
      valid_q   <= 1'b0;
      errors_q  <= '0;
      read_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      status_q  <= status_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      errors_q  <= errors_d;
      read_en_q <= read_en_d;
    end
  end

  assign READ_ENABLE   = read_en_q;
  assign MOUSE_X       = pos_x_q;
  assign MOUSE_Y       = pos_y_q;
  assign MOUSE_BUTTONS = buttons_q;
  assign PACKET_VALID  = valid_q;
  assign PACKET_ERRORS = errors_q;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Self-checking bench for mouse_packet_decoder: directed packets against a packet-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mouse_packet_decoder;

  localparam int POS_W = 8;
  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;
  localparam int TO    = 40;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             ENABLE = 1'b0;
  logic [7:0]       BYTE_READ = 8'h00;
  logic [1:0]       BYTE_ERROR_CODE = 2'b00;
  logic             BYTE_READY = 1'b0;
  logic             READ_ENABLE;
  logic [POS_W-1:0] MOUSE_X;
  logic [POS_W-1:0] MOUSE_Y;
  logic [2:0]       MOUSE_BUTTONS;
  logic             PACKET_VALID;
  logic [7:0]       PACKET_ERRORS;

  mouse_packet_decoder #(
    .POS_W(POS_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .ENABLE          (ENABLE),
    .BYTE_READ       (BYTE_READ),
    .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
    .BYTE_READY      (BYTE_READY),
    .READ_ENABLE     (READ_ENABLE),
    .MOUSE_X         (MOUSE_X),
    .MOUSE_Y         (MOUSE_Y),
    .MOUSE_BUTTONS   (MOUSE_BUTTONS),
    .PACKET_VALID    (PACKET_VALID),
    .PACKET_ERRORS   (PACKET_ERRORS)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs, maintained by the stimulus at packet level.
  int exp_x, exp_y, exp_btn, exp_err;
  bit exp_valid, exp_re;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      check("MOUSE_X",       32'(MOUSE_X),       exp_x);
      check("MOUSE_Y",       32'(MOUSE_Y),       exp_y);
      check("MOUSE_BUTTONS", 32'(MOUSE_BUTTONS), exp_btn);
      check("PACKET_VALID",  32'(PACKET_VALID),  32'(exp_valid));
      check("PACKET_ERRORS", 32'(PACKET_ERRORS), exp_err);
      check("READ_ENABLE",   32'(READ_ENABLE),   32'(exp_re));
    end
  end

  // Movement rule in plain integers: 9-bit signed delta, overflow pins it, clamp to [0, maxv].
  function automatic int axis(input int pos, input int lo, input bit sgn, input bit ovf, input int maxv);
    int d;
    int r;
    if (ovf) d = sgn ? -256 : 255;
    else     d = sgn ? lo - 256 : lo;
    r = pos + d;
    if (r < 0)    return 0;
    if (r > maxv) return maxv;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic [1:0] e);
    BYTE_READ       = b;
    BYTE_ERROR_CODE = e;
    BYTE_READY      = 1'b1;
    tick();
    BYTE_READY      = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic packet(input logic [7:0] s, input logic [7:0] b1, input logic [7:0] b2);
    send(s, 2'b00);
    idle(2);
    send(b1, 2'b00);
    idle(2);
    send(b2, 2'b00);
    tick();                 // the UPDATE cycle commits on this edge
    exp_x     = axis(exp_x, int'(b1), s[4], s[6], X_MAX);
    exp_y     = axis(exp_y, int'(b2), s[5], s[7], Y_MAX);
    exp_btn   = int'(s[2:0]);
    exp_valid = 1'b1;
    tick();
    exp_valid = 1'b0;
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    RESET = 1'b1;
    ENABLE = 1'b0;
    idle(3);
    exp_x = 79; exp_y = 59; exp_btn = 0; exp_err = 0; exp_valid = 1'b0; exp_re = 1'b0;
    chk_on = 1'b1;
    idle(1);
    check("rst_x", 32'(MOUSE_X), 79);
    check("rst_y", 32'(MOUSE_Y), 59);
    check("rst_err", 32'(PACKET_ERRORS), 0);
    RESET  = 1'b0;
    ENABLE = 1'b1;
    tick();
    exp_re = 1'b1;
    idle(2);

    // 1: basic packet
    packet(8'h08, 8'h05, 8'h03);
    check("t1_x", 32'(MOUSE_X), 84);
    check("t1_y", 32'(MOUSE_Y), 62);
    check("t1_btn", 32'(MOUSE_BUTTONS), 0);

    // 2: clamp low and high
    packet(8'h18, 8'hAE, 8'h00);
    check("t2_x_at_2", 32'(MOUSE_X), 2);
    packet(8'h18, 8'hF6, 8'h00);
    check("t2_x_clamp0", 32'(MOUSE_X), 0);
    packet(8'h08, 8'h9D, 8'h00);
    check("t2_x_157", 32'(MOUSE_X), 157);
    packet(8'h08, 8'h05, 8'h00);
    check("t2_x_clamp159", 32'(MOUSE_X), 159);

    // 3: sync bit clear dropped, then buttons
    send(8'h00, 2'b00);
    bump_err();
    idle(2);
    check("t3_err", 32'(PACKET_ERRORS), 1);
    packet(8'h09, 8'h00, 8'h00);
    check("t3_btn", 32'(MOUSE_BUTTONS), 1);
    check("t3_x", 32'(MOUSE_X), 159);

    // 4: parity error on byte 1, then good packet with negative dY
    send(8'h08, 2'b00);
    idle(2);
    send(8'h11, 2'b01);
    bump_err();
    idle(2);
    check("t4_err", 32'(PACKET_ERRORS), 2);
    packet(8'h28, 8'h01, 8'hFE);
    check("t4_y", 32'(MOUSE_Y), 60);

    // 5: timeout after byte 0, late byte starts a new packet
    send(8'h08, 2'b00);
    idle(TO - 1);
    tick();
    bump_err();
    idle(2);
    check("t5_err", 32'(PACKET_ERRORS), 3);
    packet(8'h18, 8'hFB, 8'h00);
    check("t5_x", 32'(MOUSE_X), 154);

    // 6: overflow saturation, then ENABLE abort mid-packet
    packet(8'h48, 8'h00, 8'h00);
    check("t6_xov", 32'(MOUSE_X), 159);
    packet(8'hA8, 8'h00, 8'h00);
    check("t6_yov", 32'(MOUSE_Y), 0);
    send(8'h08, 2'b00);
    idle(2);
    send(8'h10, 2'b00);
    idle(1);
    ENABLE = 1'b0;
    tick();
    exp_re = 1'b0;
    idle(3);
    ENABLE = 1'b1;
    tick();
    exp_re = 1'b1;
    idle(2);
    packet(8'h18, 8'hFD, 8'h00);
    check("t6_after_abort_x", 32'(MOUSE_X), 156);
    check("t6_after_abort_y", 32'(MOUSE_Y), 0);

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      send(8'h00, 2'b00);
      bump_err();
      idle(1);
    end
    check("err_saturated", 32'(PACKET_ERRORS), 255);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
